// File: rtl/bp_pkg.sv
// ============================================================================
// Module   : bp_pkg
// Brief    : Shared counter type, constants and saturating update helper for
//            the PHT branch direction predictor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int CTR_W_MAX = 4;
    localparam int CTR_W_DEF = 2;

    // Container wide enough for every legal counter width; narrower counters
    // are zero-extended into it and truncated back afterwards.
    typedef logic [CTR_W_MAX-1:0] ctr_t;

    localparam ctr_t CTR_MAX = ctr_t'((1 << CTR_W_DEF) - 1);
    localparam ctr_t CTR_WNT = ctr_t'((1 << (CTR_W_DEF - 1)) - 1);

    function automatic ctr_t ctr_max_of(input int unsigned w);
        return ctr_t'((1 << w) - 1);
    endfunction

    function automatic ctr_t ctr_wnt_of(input int unsigned w);
        return ctr_t'((1 << (w - 1)) - 1);
    endfunction

    function automatic ctr_t sat_inc_dec(input ctr_t ctr, input logic take, input ctr_t max);
        ctr_t res;
        res = ctr;
        if (take) begin
            if (ctr != max) res = ctr + ctr_t'(1);
        end else begin
            if (ctr != '0) res = ctr - ctr_t'(1);
        end
        return res;
    endfunction

endpackage : bp_pkg

`default_nettype wire

// File: rtl/bp_sat_ctr.sv
// ============================================================================
// Module   : bp_sat_ctr
// Brief    : Single CTR_W-bit saturating up/down counter, sync active-low
//            reset to weakly-not-taken, update gated by i_en.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_take,
    output logic [CTR_W-1:0]      o_ctr
);

    localparam ctr_t C_MAX = ctr_max_of(CTR_W);
    localparam ctr_t C_WNT = ctr_wnt_of(CTR_W);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    ctr_t             ctr_ext;
    ctr_t             ctr_next;

    always_comb begin
        ctr_ext              = '0;
        ctr_ext[CTR_W-1:0]   = ctr_q;
        ctr_next             = sat_inc_dec(ctr_ext, i_take, C_MAX);
        ctr_d                = ctr_q;
        if (i_en) ctr_d = ctr_next[CTR_W-1:0];
    end

    generate
        if (CTR_W < CTR_W_MAX) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^ctr_next[CTR_W_MAX-1:CTR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) ctr_q <= C_WNT[CTR_W-1:0];
        else      ctr_q <= ctr_d;
    end

    assign o_ctr = ctr_q;

endmodule : bp_sat_ctr

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Brief    : PHT direction predictor; combinational read from pcF, trained by
//            the E stage. Optional gshare indexing via macro BP_GSHARE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int PHT_DEPTH = 256,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic [PC_W-1:0]              pcF,
    output logic                              predict_takeF,
    output logic [$clog2(PHT_DEPTH)-1:0]      pred_idxF,
    input  wire logic                         update_en,
    input  wire logic [$clog2(PHT_DEPTH)-1:0] update_idx,
    input  wire logic                         update_take,
    output logic                              mispredictE
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [CTR_W-1:0] pht [PHT_DEPTH];
    logic [IDX_W-1:0] base_idx;
    logic             unused_pc_bits;
    logic             mispredict_q;
    logic             mispredict_d;

    assign base_idx       = pcF[IDX_W+1:2];
    assign unused_pc_bits = ^{pcF[PC_W-1:IDX_W+2], pcF[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [IDX_W-1:0] ghr_ext;

    // History advances only at resolution, so it is never speculative.
    always_comb begin
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_q;
        ghr_d                = ghr_q;
        if (update_en) ghr_d = (ghr_q << 1) | GHR_W'(update_take);
    end

    always_ff @(posedge clk) begin
        if (!rst) ghr_q <= '0;
        else      ghr_q <= ghr_d;
    end

    assign pred_idxF = base_idx ^ ghr_ext;
`else
    assign pred_idxF = base_idx;
`endif

    assign predict_takeF = pht[pred_idxF][CTR_W-1];

    always_comb begin
        mispredict_d = 1'b0;
        if (update_en) mispredict_d = (pht[update_idx][CTR_W-1] != update_take);
    end

    always_ff @(posedge clk) begin
        if (!rst) mispredict_q <= 1'b0;
        else      mispredict_q <= mispredict_d;
    end

    assign mispredictE = mispredict_q;

    generate
        for (genvar i = 0; i < PHT_DEPTH; i++) begin : g_pht
            bp_sat_ctr #(
                .CTR_W (CTR_W)
            ) u_ctr (
                .clk    (clk),
                .rst    (rst),
                .i_en   (update_en && (update_idx == IDX_W'(i))),
                .i_take (update_take),
                .o_ctr  (pht[i])
            );
        end
    endgenerate

endmodule : branch_predictor

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed vector table plus randomized run against a behavioural
//            PHT model for branch_predictor (default and BP_GSHARE_EN builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam int PC_W  = 32;
    localparam int DEPTH = 256;
    localparam int IDX_W = 8;
    localparam int CTR_W = 2;
    localparam int GHR_W = 8;
    localparam int C_MAX = (1 << CTR_W) - 1;
    localparam int C_HALF = 1 << (CTR_W - 1);

    logic             clk;
    logic             rst;
    logic [PC_W-1:0]  pcF;
    logic             predict_takeF;
    logic [IDX_W-1:0] pred_idxF;
    logic             update_en;
    logic [IDX_W-1:0] update_idx;
    logic             update_take;
    logic             mispredictE;

    branch_predictor #(
        .PC_W      (PC_W),
        .PHT_DEPTH (DEPTH),
        .CTR_W     (CTR_W),
        .GHR_W     (GHR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pcF           (pcF),
        .predict_takeF (predict_takeF),
        .pred_idxF     (pred_idxF),
        .update_en     (update_en),
        .update_idx    (update_idx),
        .update_take   (update_take),
        .mispredictE   (mispredictE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: plain integer counters and history.
    int m_pht [DEPTH];
    int m_ghr;
    int m_mis;

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_pht[i] = C_HALF - 1;
        m_ghr = 0;
        m_mis = 0;
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        int base;
        base = int'((pc >> 2) % DEPTH);
`ifdef BP_GSHARE_EN
        return base ^ m_ghr;
`else
        return base;
`endif
    endfunction

    task automatic m_clock(input logic r, input logic en, input int idx, input logic take);
        if (!r) begin
            m_reset();
        end else if (en) begin
            m_mis = ((m_pht[idx] >= C_HALF) != take) ? 1 : 0;
            if (take) m_pht[idx] = (m_pht[idx] < C_MAX) ? m_pht[idx] + 1 : C_MAX;
            else      m_pht[idx] = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
            m_ghr = ((m_ghr << 1) | int'(take)) % (1 << GHR_W);
        end else begin
            m_mis = 0;
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic en,
                         input logic [7:0] idx, input logic take);
        rst         = r;
        pcF         = pc;
        update_en   = en;
        update_idx  = idx;
        update_take = take;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        en;
        logic [7:0]  idx;
        logic        take;
        logic        exp_pred;
        logic [7:0]  exp_idx;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial begin
        // Row: inputs held for one cycle; pred/idx checked before the edge,
        // mispredictE checked after it.
        vecs[0]  = '{1'b1, 32'h0040_0014, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0};
        vecs[1]  = '{1'b1, 32'h0040_0014, 1'b1, 8'h05, 1'b1, 1'b0, 8'h05, 1'b1};
        vecs[2]  = '{1'b1, 32'h0040_0014, 1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0};
        vecs[3]  = '{1'b1, 32'h0040_0014, 1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0};
        vecs[4]  = '{1'b1, 32'h0040_0014, 1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1};
        vecs[5]  = '{1'b1, 32'h0040_0014, 1'b0, 8'h33, 1'b0, 1'b1, 8'h05, 1'b0};
        vecs[6]  = '{1'b1, 32'h0040_001C, 1'b1, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0};
        vecs[7]  = '{1'b1, 32'h0040_001C, 1'b1, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0};
        vecs[8]  = '{1'b1, 32'h0040_001C, 1'b0, 8'h00, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[9]  = '{1'b1, 32'h0040_0024, 1'b1, 8'h09, 1'b1, 1'b0, 8'h09, 1'b1};
        vecs[10] = '{1'b1, 32'h0040_0024, 1'b0, 8'h00, 1'b0, 1'b1, 8'h09, 1'b0};
        vecs[11] = '{1'b1, 32'h0040_0014, 1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0};
        vecs[12] = '{1'b0, 32'h0040_0014, 1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0};
        vecs[13] = '{1'b1, 32'h0040_0014, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0};
        vecs[14] = '{1'b1, 32'h0040_0027, 1'b0, 8'h00, 1'b0, 1'b0, 8'h09, 1'b0};

        drive(1'b0, 32'h0040_0014, 1'b0, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("reset_pred", {31'd0, predict_takeF}, 32'd0);
        check("reset_idx",  {24'd0, pred_idxF},     32'h05);
        check("reset_mis",  {31'd0, mispredictE},   32'd0);

`ifndef BP_GSHARE_EN
        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].rst, vecs[v].pc, vecs[v].en, vecs[v].idx, vecs[v].take);
            #1;
            check($sformatf("vec%0d_pred", v), {31'd0, predict_takeF}, {31'd0, vecs[v].exp_pred});
            check($sformatf("vec%0d_idx", v),  {24'd0, pred_idxF},     {24'd0, vecs[v].exp_idx});
            step();
            check($sformatf("vec%0d_mis", v),  {31'd0, mispredictE},   {31'd0, vecs[v].exp_mis});
        end
`else
        drive(1'b1, 32'h0040_0040, 1'b1, 8'h30, 1'b1);
        step();
        drive(1'b1, 32'h0040_0040, 1'b1, 8'h30, 1'b1);
        step();
        drive(1'b1, 32'h0040_0040, 1'b1, 8'h30, 1'b0);
        step();
        drive(1'b1, 32'h0040_0040, 1'b0, 8'h00, 1'b0);
        #1;
        check("gshare_idx_hist", {24'd0, pred_idxF}, 32'h16);
        drive(1'b0, 32'h0040_0040, 1'b1, 8'h30, 1'b1);
        step();
        drive(1'b1, 32'h0040_0040, 1'b0, 8'h00, 1'b0);
        #1;
        check("gshare_idx_rst", {24'd0, pred_idxF}, 32'h10);
        check("gshare_mis_rst", {31'd0, mispredictE}, 32'd0);
`endif

        drive(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        step();
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [31:0] pc;
            logic        en;
            logic [7:0]  idx;
            logic        take;
            int          e_idx;
            r    = ($urandom_range(0, 63) != 0);
            pc   = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            en   = ($urandom_range(0, 3) != 0);
            idx  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 15));
            take = ($urandom_range(0, 99) < 70);
            drive(r, pc, en, idx, take);
            #1;
            e_idx = m_idx(pc);
            check("rand_idx",  {24'd0, pred_idxF},     32'(e_idx));
            check("rand_pred", {31'd0, predict_takeF}, (m_pht[e_idx] >= C_HALF) ? 32'd1 : 32'd0);
            m_clock(r, en, int'(idx), take);
            step();
            check("rand_mis",  {31'd0, mispredictE},   32'(m_mis));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_branch_predictor

`default_nettype wire
